// File: rtl/im_box_downscale_pkg.sv
// Shared types and width helpers for the box-filter downscaler.
// The state encoding and derived-width functions are used by the top and the accumulator.
package im_proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Bits needed to hold n distinct values (never less than one bit)
  function automatic int unsigned f_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Accumulator width that cannot overflow for 2^shift summands of ch_w bits
  function automatic int unsigned f_acc_w(input int unsigned ch_w, input int unsigned shift);
    return ch_w + shift;
  endfunction

  // Packed pixel width for a given channel count and channel width
  function automatic int unsigned f_pix_w(input int unsigned channels, input int unsigned ch_w);
    return channels * ch_w;
  endfunction

endpackage

// File: rtl/im_box_downscale_if.sv
// Frame-buffer read/write bus and start/status handshake of the downscaler.
// The master modport is the engine side; slave is the memory/controller side.
interface im_box_downscale_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IN_AW  = 19,
  parameter int unsigned OUT_AW = 15
);

  logic [DATA_W-1:0] idata_rd;
  logic [IN_AW-1:0]  oaddr_rd;
  logic              omem_rd_en;
  logic [DATA_W-1:0] odata_wr;
  logic [OUT_AW-1:0] oaddr_wr;
  logic              omem_wr_en;
  logic [IN_AW-1:0]  idata_start_ptr;
  logic              istart_work;
  logic              omodule_work_f;
  logic              omodule_done_f;

  modport master (
    input  idata_rd, idata_start_ptr, istart_work,
    output oaddr_rd, omem_rd_en, odata_wr, oaddr_wr, omem_wr_en,
           omodule_work_f, omodule_done_f
  );

  modport slave (
    output idata_rd, idata_start_ptr, istart_work,
    input  oaddr_rd, omem_rd_en, odata_wr, oaddr_wr, omem_wr_en,
           omodule_work_f, omodule_done_f
  );

endinterface

// File: rtl/im_box_downscale_accum.sv
// One colour channel: read-latency valid line, block accumulator and mean extraction.
// Build option IM_BOX_DOWNSCALE_ROUND_EN selects round-half-up with clamp instead of truncation.
module im_box_accum
  import im_proc_pkg::*;
#(
  parameter int unsigned pCH_W       = 8,
  parameter int unsigned pSHIFT      = 4,
  parameter int unsigned pRD_LATENCY = 1
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             i_rd_en,
  input  logic             i_clr,
  input  logic [pCH_W-1:0] i_data,
  output logic [pCH_W-1:0] o_avg_c
);

  localparam int unsigned ACC_W = f_acc_w(pCH_W, pSHIFT);

  logic [pRD_LATENCY-1:0] r_vld;
  logic [ACC_W-1:0]       r_acc;
  logic                   w_vld;
  logic [ACC_W-1:0]       w_sum;

  // Valid bit follows the read strobe by the memory latency
  generate
    if (pRD_LATENCY > 1) begin : g_dly
      always_ff @(posedge iclk or posedge irst) begin
        if (irst) r_vld <= '0;
        else      r_vld <= {r_vld[pRD_LATENCY-2:0], i_rd_en};
      end
    end else begin : g_one
      always_ff @(posedge iclk or posedge irst) begin
        if (irst) r_vld <= '0;
        else      r_vld <= i_rd_en;
      end
    end
  endgenerate

  assign w_vld = r_vld[pRD_LATENCY-1];

  // w_sum includes the sample arriving this cycle, so the mean is ready as the last one lands
  always_comb begin
    w_sum = r_acc;
    if (w_vld) w_sum = r_acc + ACC_W'(i_data);
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else            r_acc <= w_sum;
  end

`ifdef IM_BOX_DOWNSCALE_ROUND_EN
  localparam int unsigned RND_W = ACC_W + 1;
  localparam int unsigned SHF_W = pCH_W + 1;
  localparam int unsigned HALF  = (pSHIFT > 0) ? (1 << (pSHIFT - 1)) : 0;

  logic [RND_W-1:0] w_rnd;
  logic [SHF_W-1:0] w_shf;

  always_comb begin
    w_rnd   = RND_W'(w_sum) + RND_W'(HALF);
    w_shf   = SHF_W'(w_rnd >> pSHIFT);
    o_avg_c = w_shf[pCH_W] ? '1 : w_shf[pCH_W-1:0];
  end
`else
  always_comb begin
    o_avg_c = pCH_W'(w_sum >> pSHIFT);
  end
`endif

endmodule

// File: rtl/im_box_downscale.sv
// Whole-frame box-filter downscaler: reads each 2^W x 2^H block, writes its per-channel mean.
// Build option IM_BOX_DOWNSCALE_ROUND_EN enables round-half-up with clamp in each channel.
module im_box_downscale
  import im_proc_pkg::*;
#(
  parameter int unsigned pIN_IM_WIDTH  = 640,
  parameter int unsigned pIN_IM_HEIGHT = 480,
  parameter int unsigned pAREA_LOG2_W  = 2,
  parameter int unsigned pAREA_LOG2_H  = 2,
  parameter int unsigned pCHANNELS     = 3,
  parameter int unsigned pCH_W         = 8,
  parameter int unsigned pRD_LATENCY   = 1
) (
  input logic          iclk,
  input logic          irst,
  im_box_downscale_if.master bus
);

  localparam int unsigned AW_PIX = 1 << pAREA_LOG2_W;
  localparam int unsigned AH_PIX = 1 << pAREA_LOG2_H;
  localparam int unsigned SHIFT  = pAREA_LOG2_W + pAREA_LOG2_H;
  localparam int unsigned DATA_W = f_pix_w(pCHANNELS, pCH_W);
  localparam int unsigned OUT_W  = pIN_IM_WIDTH >> pAREA_LOG2_W;
  localparam int unsigned OUT_H  = pIN_IM_HEIGHT >> pAREA_LOG2_H;
  localparam int unsigned IN_AW  = f_width(pIN_IM_WIDTH * pIN_IM_HEIGHT);
  localparam int unsigned OUT_AW = f_width(OUT_W * OUT_H);
  localparam int unsigned RX_W   = f_width(AW_PIX);
  localparam int unsigned RY_W   = f_width(AH_PIX);
  localparam int unsigned OX_W   = f_width(OUT_W);
  localparam int unsigned OY_W   = f_width(OUT_H);
  localparam int unsigned LAT_W  = f_width(pRD_LATENCY);

  state_t            r_state, w_state_nxt;
  logic [IN_AW-1:0]  r_base, w_base_nxt;
  logic [OX_W-1:0]   r_ox, w_ox_nxt;
  logic [OY_W-1:0]   r_oy, w_oy_nxt;
  logic [RX_W-1:0]   r_rx, w_rx_nxt;
  logic [RY_W-1:0]   r_ry, w_ry_nxt;
  logic [LAT_W-1:0]  r_lat, w_lat_nxt;

  logic [IN_AW-1:0]  r_addr_rd, w_addr_rd_nxt;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_data_wr;
  logic [OUT_AW-1:0] r_addr_wr;
  logic              r_wr_en;
  logic              r_work;
  logic              r_done;

  logic              w_acc_clr;
  logic [DATA_W-1:0] w_avg;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_ox    <= w_ox_nxt;
      r_oy    <= w_oy_nxt;
      r_rx    <= w_rx_nxt;
      r_ry    <= w_ry_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    w_rx_nxt    = r_rx;
    w_ry_nxt    = r_ry;
    w_lat_nxt   = r_lat;
    case (r_state)
      S_IDLE: begin
        if (bus.istart_work) begin
          w_state_nxt = S_READ;
          w_base_nxt  = bus.idata_start_ptr;
          w_ox_nxt    = '0;
          w_oy_nxt    = '0;
          w_rx_nxt    = '0;
          w_ry_nxt    = '0;
        end
      end
      // rx runs inside ry; the block is finished when both wrap together
      S_READ: begin
        if (r_rx == RX_W'(AW_PIX - 1)) begin
          w_rx_nxt = '0;
          if (r_ry == RY_W'(AH_PIX - 1)) begin
            w_ry_nxt    = '0;
            w_lat_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_ry_nxt = r_ry + 1'b1;
          end
        end else begin
          w_rx_nxt = r_rx + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_lat == LAT_W'(pRD_LATENCY - 1)) w_state_nxt = S_WRITE;
        else                                  w_lat_nxt   = r_lat + 1'b1;
      end
      S_WRITE: begin
        w_state_nxt = S_READ;
        if (r_ox == OX_W'(OUT_W - 1)) begin
          w_ox_nxt = '0;
          if (r_oy == OY_W'(OUT_H - 1)) begin
            w_oy_nxt    = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_oy_nxt = r_oy + 1'b1;
          end
        end else begin
          w_ox_nxt = r_ox + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address of the pixel the next READ cycle presents; wraps modulo 2^IN_AW
  always_comb begin
    w_addr_rd_nxt = IN_AW'(32'(w_base_nxt)
                         + (32'(w_oy_nxt) * AH_PIX + 32'(w_ry_nxt)) * pIN_IM_WIDTH
                         + 32'(w_ox_nxt) * AW_PIX + 32'(w_rx_nxt));
  end

  assign w_acc_clr = (w_state_nxt == S_READ) && (r_state != S_READ);

  // Outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_addr_rd <= '0;
      r_rd_en   <= 1'b0;
      r_data_wr <= '0;
      r_addr_wr <= '0;
      r_wr_en   <= 1'b0;
      r_work    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en <= (w_state_nxt == S_READ);
      r_wr_en <= (w_state_nxt == S_WRITE);
      r_work  <= (w_state_nxt == S_READ) || (w_state_nxt == S_DRAIN) ||
                 (w_state_nxt == S_WRITE);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_READ) r_addr_rd <= w_addr_rd_nxt;
      if (w_state_nxt == S_WRITE) begin
        r_addr_wr <= OUT_AW'(32'(r_oy) * OUT_W + 32'(r_ox));
        r_data_wr <= w_avg;
      end
    end
  end

  generate
    for (genvar c = 0; c < pCHANNELS; c++) begin : g_ch
      im_box_accum #(
        .pCH_W       (pCH_W),
        .pSHIFT      (SHIFT),
        .pRD_LATENCY (pRD_LATENCY)
      ) u_accum (
        .iclk    (iclk),
        .irst    (irst),
        .i_rd_en (r_rd_en),
        .i_clr   (w_acc_clr),
        .i_data  (bus.idata_rd[c*pCH_W +: pCH_W]),
        .o_avg_c (w_avg[c*pCH_W +: pCH_W])
      );
    end
  endgenerate

  assign bus.oaddr_rd       = r_addr_rd;
  assign bus.omem_rd_en     = r_rd_en;
  assign bus.odata_wr       = r_data_wr;
  assign bus.oaddr_wr       = r_addr_wr;
  assign bus.omem_wr_en     = r_wr_en;
  assign bus.omodule_work_f = r_work;
  assign bus.omodule_done_f = r_done;

endmodule

// File: tb/tb_im_box_downscale.sv
// Scoreboard bench for im_box_downscale on an 8x4 frame with 2x2 boxes and 3-cycle read latency.
// Honours IM_BOX_DOWNSCALE_ROUND_EN in its reference model.
module tb_im_box_downscale;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int BW    = 2;
  localparam int BH    = 2;
  localparam int NPIX  = BW * BH;
  localparam int OUT_W = W / BW;
  localparam int OUT_H = H / BH;
  localparam int INSZ  = W * H;
  localparam int LAT   = 3;
  localparam int FRAME_CYC = OUT_W * OUT_H * (NPIX + LAT + 1) + 1;

  typedef struct packed {
    logic [2:0]  addr;
    logic [23:0] data;
  } wr_t;

  logic iclk;
  logic irst;

  im_box_downscale_if #(.DATA_W(24), .IN_AW(5), .OUT_AW(3)) bus ();

  im_box_downscale #(
    .pIN_IM_WIDTH  (W),
    .pIN_IM_HEIGHT (H),
    .pAREA_LOG2_W  (1),
    .pAREA_LOG2_H  (1),
    .pCHANNELS     (3),
    .pCH_W         (8),
    .pRD_LATENCY   (LAT)
  ) u_dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  logic [23:0] mem  [INSZ];
  logic [23:0] pipe [LAT];
  wr_t         exp_wr [$];
  logic [4:0]  exp_rd [$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_wr   = 0;
  int n_done = 0;

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  // Frame memory with LAT-cycle read latency; junk on the bus when not reading
  always @(posedge iclk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= bus.omem_rd_en ? mem[bus.oaddr_rd] : 24'($urandom);
  end
  assign bus.idata_rd = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen as expected", name);
  endtask

  // Monitor: every read strobe and write strobe is matched against the scoreboard
  always @(negedge iclk) begin
    if (!irst) begin
      if (bus.omem_rd_en) begin
        if (exp_rd.size() == 0) miss("rd_unexpected");
        else chk("rd_addr", 64'(bus.oaddr_rd), 64'(exp_rd.pop_front()));
      end
      if (bus.omem_wr_en) begin
        wr_t e;
        n_wr++;
        if (exp_wr.size() == 0) miss("wr_unexpected");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(bus.oaddr_wr), 64'(e.addr));
          chk("wr_data", 64'(bus.odata_wr), 64'(e.data));
        end
      end
      if (bus.omodule_done_f) n_done++;
    end
  end

  // Reference: mean of each box of the image seen from the base address
  task automatic load_expect(input int base);
    for (int oy = 0; oy < OUT_H; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        int unsigned sum [3];
        int unsigned v;
        wr_t e;
        for (int c = 0; c < 3; c++) sum[c] = 0;
        for (int ry = 0; ry < BH; ry++) begin
          for (int rx = 0; rx < BW; rx++) begin
            int a;
            a = (base + (oy * BH + ry) * W + ox * BW + rx) % INSZ;
            exp_rd.push_back(5'(a));
            for (int c = 0; c < 3; c++) sum[c] += 32'(mem[a][8*c +: 8]);
          end
        end
        e.addr = 3'(oy * OUT_W + ox);
        e.data = '0;
        for (int c = 0; c < 3; c++) begin
`ifdef IM_BOX_DOWNSCALE_ROUND_EN
          v = (sum[c] + NPIX / 2) / NPIX;
          if (v > 255) v = 255;
`else
          v = sum[c] / NPIX;
`endif
          e.data[8*c +: 8] = 8'(v);
        end
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic fill(input int pat);
    for (int a = 0; a < INSZ; a++) begin
      case (pat)
        0:       mem[a] = 24'h404040;
        1:       mem[a] = {3{8'(a % W)}};
        2:       mem[a] = 24'hFFFFFF;
        default: mem[a] = 24'($urandom);
      endcase
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.oaddr_rd, bus.omem_rd_en, bus.odata_wr, bus.oaddr_wr,
                bus.omem_wr_en, bus.omodule_work_f, bus.omodule_done_f});
  endfunction

  task automatic do_reset();
    irst = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    repeat (2) @(negedge iclk);
    irst = 1'b0;
  endtask

  task automatic run_frame(input int pat, input int base, input bit extra);
    int cnt;
    bit got;
    int wr0;
    int dn0;
    fill(pat);
    load_expect(base);
    wr0 = n_wr;
    dn0 = n_done;
    bus.idata_start_ptr = 5'(base);
    @(negedge iclk);
    bus.istart_work = 1'b1;
    @(posedge iclk);
    cnt = 1;
    #1 chk("work_rise", 64'(bus.omodule_work_f), 64'd1);
    @(negedge iclk);
    bus.istart_work = 1'b0;
    got = 1'b0;
    while (!got && cnt < 2000) begin
      @(posedge iclk);
      cnt++;
      #1;
      if (extra && cnt == 2) bus.istart_work = 1'b1;
      if (extra && cnt == 3) bus.istart_work = 1'b0;
      if (bus.omodule_done_f) got = 1'b1;
    end
    if (!got) begin
      miss("done_timeout");
      do_reset();
    end else begin
      chk("done_cycle", 64'(cnt), 64'(FRAME_CYC));
      chk("work_at_done", 64'(bus.omodule_work_f), 64'd0);
      repeat (3) @(negedge iclk);
      #1;
      chk("done_count", 64'(n_done - dn0), 64'd1);
      chk("write_count", 64'(n_wr - wr0), 64'(OUT_W * OUT_H));
      chk("rd_left", 64'(exp_rd.size()), 64'd0);
      chk("done_low", 64'(bus.omodule_done_f), 64'd0);
    end
  endtask

  initial begin
    int pats  [7] = '{0, 1, 2, 3, 3, 3, 3};
    int bases [7] = '{0, 0, 0, 5, -1, 0, 31};
    bit extras[7] = '{0, 0, 0, 0, 0, 1, 0};
    int wr1;
    bit hit;
    irst = 1'b1;
    bus.istart_work = 1'b0;
    bus.idata_start_ptr = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    repeat (3) @(negedge iclk);
    chk("reset_outs", all_outs(), 64'd0);
    irst = 1'b0;
    repeat (2) @(negedge iclk);

    for (int f = 0; f < 7; f++) begin
      run_frame(pats[f], (bases[f] < 0) ? int'($urandom_range(0, INSZ - 1)) : bases[f], extras[f]);
      repeat (2) @(negedge iclk);
    end

    // Reset pulsed during the third write aborts the frame
    fill(3);
    load_expect(0);
    wr1 = n_wr;
    bus.idata_start_ptr = '0;
    @(negedge iclk);
    bus.istart_work = 1'b1;
    @(negedge iclk);
    bus.istart_work = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge iclk);
      #1;
      if (n_wr - wr1 >= 3) hit = 1'b1;
    end
    if (!hit) miss("third_write_timeout");
    irst = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    @(posedge iclk);
    #1 chk("abort_outs", all_outs(), 64'd0);
    @(negedge iclk);
    irst = 1'b0;
    wr1 = n_wr;
    repeat (40) @(negedge iclk);
    #1 chk("no_write_after_abort", 64'(n_wr - wr1), 64'd0);
    run_frame(3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
